sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives a 1R1W SRAM macro as its storage, acting as the initiator on both macro ports. It owns the write port (A2/CSB2/WEB2/I2) and the read port (A1/CSB1/OEB1/O1). It presents ready/valid enqueue and dequeue interfaces to the rest of the design. A 2-entry register output buffer hides the macro's 1-cycle read latency, sustaining 1 enq + 1 deq per cycle.

Parameters:
DATA_W, 32, word width; must match the macro data width
ADDR_W, 9, macro address width; SRAM depth DEPTH = 2**ADDR_W (512)
CNT_W, 10, occupancy width; must hold DEPTH+2

Ports:
clk  in  1  clock; also drives the macro's CE1/CE2 (tied externally)
reset_n  in  1  asynchronous active-low reset
enq_valid  in  1  producer has data
enq_ready  out  1  FIFO accepts data this cycle
enq_bits  in  DATA_W  enqueue data
deq_valid  out  1  head entry valid
deq_ready  in  1  consumer takes head
deq_bits  out  DATA_W  head data
count  out  CNT_W  total occupancy
sram_a1  out  ADDR_W  read address
sram_csb1  out  1  read chip select, active low
sram_oeb1  out  1  read output enable, active low
sram_o1  in  DATA_W  read data; valid the cycle after a read is issued
sram_a2  out  ADDR_W  write address
sram_csb2  out  1  write chip select, active low
sram_web2  out  1  write enable, active low
sram_i2  out  DATA_W  write data

Behaviour:
- State: wr_ptr, rd_ptr (ADDR_W; wrap DEPTH-1 -> 0), sram_cnt (0..DEPTH), inflight (1 bit), ob_cnt (0..2), 2-entry output buffer (ob).
- Reset (async, while reset_n=0):
  - State: pointers, counts, and inflight = 0; sram_oeb1 = 1.
  - Outputs: enq_ready = 1, deq_valid = 0, count = 0, sram_csb1 = sram_csb2 = sram_web2 = 1.
  - sram_oeb1 is registered and goes to 0 on the first clk edge after release.
- Fire definitions: enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
- enq_ready = (sram_cnt != DEPTH). It depends on state only, never on enq_valid or deq_ready.
- Bypass: if enq_fire & sram_cnt==0 & inflight==0 & ob_cnt<2, the word goes straight into ob and no SRAM write occurs. Latency is 1: deq_valid is high the cycle after enq.
- SRAM write: any other enq_fire drives csb2 = web2 = 0, a2 = wr_ptr, i2 = enq_bits. wr_ptr++ and sram_cnt++.
- SRAM read issue:
  - Condition: sram_cnt>0 & (ob_cnt + inflight - deq_fire) < 2.
  - Action: csb1 = 0, a1 = rd_ptr; rd_ptr++, sram_cnt--, inflight is set next cycle.
  - Only words written in earlier cycles are readable, so there is no same-address read/write hazard.
  - deq_ready -> csb1 is a combinational path (accepted).
- Capture: when inflight=1, sram_o1 is written into ob at the tail that cycle.
- SRAM-path latency: write at edge t, read issued in cycle t+1, captured end of t+2, deq_valid in t+3.
- Output buffer:
  - deq_bits = ob head; deq_valid = (ob_cnt>0).
  - deq_fire pops the head; the second entry shifts to the head in the same cycle as any push.
- Simultaneous push + pop keeps ob_cnt unchanged; a push into ob_cnt==2 never occurs (invariant; assert in sim).
- count = sram_cnt + inflight + ob_cnt, registered-state sum. Capacity is DEPTH+2 = 514.
- When sram_cnt==DEPTH with a simultaneous read issue, enq_ready stays 0 that cycle and rises the next cycle.
- FIFO order is strictly preserved across bypass, SRAM, and capture paths.
- Reset mid-operation: all contents are discarded. No SRAM access while reset_n=0; csb1 and csb2 are forced high combinationally.
- When idle, csb1 = csb2 = 1; a1, a2, and i2 are don't-care but held at their last value (no toggling).

Test Plan:
- Reset: assert reset_n=0 mid-stream -> deq_valid=0, count=0, enq_ready=1, csb1=csb2=1 immediately; first deq after release returns the first post-reset word.
- Bypass: on an empty FIFO, enq 0xA5A5A5A5 at cycle 0 -> deq_valid=1 with deq_bits=0xA5A5A5A5 at cycle 1; csb2 stays 1.
- Fill: deq_ready=0, enq 0..600 -> enq_ready drops after 514 accepts, count=514, exactly 512 SRAM writes. Then deq_ready=1 -> 0..513 out in order, count returns to 0.
- Throughput: enq_valid=deq_ready=1 continuously with 4 words preloaded -> one deq per cycle with no bubbles over 1000 words; count stays 4.
- Wraparound: stream 1500 words (data = index) with random enq_valid/deq_ready at 50% -> output equals 0..1499 in order; wr_ptr/rd_ptr wrap 511 -> 0 at least twice.
- Full boundary: at count=514 with deq_ready pulsed for one cycle -> count 513, enq_ready re-asserts within 2 cycles, next enq lands in the SRAM and order is preserved.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sram_fifo_ctrl                                                    |
// | Brief  : Ready/valid FIFO backed by a 1R1W SRAM macro, with a 2-entry      |
// |          register output buffer that hides the macro's read latency.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sram_fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] sram_a1,
  output logic              sram_csb1,
  output logic              sram_oeb1,
  input  logic [DATA_W-1:0] sram_o1,
  output logic [ADDR_W-1:0] sram_a2,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic [DATA_W-1:0] sram_i2
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_sram_cnt;
  logic              r_inflight;
  logic [1:0]        r_ob_cnt;
  logic [DATA_W-1:0] r_ob0;
  logic [DATA_W-1:0] r_ob1;
  logic              r_oeb1;
  logic [ADDR_W-1:0] r_a1_hold;
  logic [ADDR_W-1:0] r_a2_hold;
  logic [DATA_W-1:0] r_i2_hold;

  logic              w_enq_fire;
  logic              w_deq_fire;
  logic              w_bypass;
  logic              w_sram_wr;
  logic              w_rd_issue;
  logic [2:0]        w_rd_slots;
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic [1:0]        w_ob_base;
  logic [DATA_W-1:0] w_ob0_nxt;
  logic [DATA_W-1:0] w_ob1_nxt;
  logic [1:0]        w_ob_cnt_nxt;
  logic [ADDR_W:0]   w_sram_cnt_nxt;

  assign enq_ready  = (r_sram_cnt != c_DEPTH);
  assign deq_valid  = (r_ob_cnt != 2'd0);
  assign deq_bits   = r_ob0;
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;

  // An empty SRAM with nothing in flight means the word can skip the macro.
  assign w_bypass  = w_enq_fire && (r_sram_cnt == '0) && !r_inflight && (r_ob_cnt != 2'd2);
  assign w_sram_wr = w_enq_fire && !w_bypass && reset_n;

  // Read only when the buffer slot it will land in is guaranteed free.
  assign w_rd_slots = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_deq_fire};
  assign w_rd_issue = (r_sram_cnt != '0) && (w_rd_slots < 3'd2) && reset_n;

  assign w_push      = w_bypass | r_inflight;
  assign w_push_data = w_bypass ? enq_bits : sram_o1;
  assign w_ob_base   = r_ob_cnt - {1'b0, w_deq_fire};

  always_comb begin
    w_ob0_nxt    = r_ob0;
    w_ob1_nxt    = r_ob1;
    w_ob_cnt_nxt = w_ob_base + {1'b0, w_push};
    if (w_deq_fire) begin
      w_ob0_nxt = r_ob1;
    end
    if (w_push) begin
      if (w_ob_base == 2'd0) begin
        w_ob0_nxt = w_push_data;
      end else begin
        w_ob1_nxt = w_push_data;
      end
    end
  end

  assign w_sram_cnt_nxt = r_sram_cnt + (ADDR_W+1)'(w_sram_wr) - (ADDR_W+1)'(w_rd_issue);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sram_cnt <= '0;
      r_inflight <= 1'b0;
      r_ob_cnt   <= 2'd0;
      r_ob0      <= '0;
      r_ob1      <= '0;
      r_oeb1     <= 1'b1;
      r_a1_hold  <= '0;
      r_a2_hold  <= '0;
      r_i2_hold  <= '0;
    end else begin
      r_oeb1     <= 1'b0;
      r_sram_cnt <= w_sram_cnt_nxt;
      r_inflight <= w_rd_issue;
      r_ob_cnt   <= w_ob_cnt_nxt;
      r_ob0      <= w_ob0_nxt;
      r_ob1      <= w_ob1_nxt;
      if (w_sram_wr) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_a2_hold <= r_wr_ptr;
        r_i2_hold <= enq_bits;
      end
      if (w_rd_issue) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_a1_hold <= r_rd_ptr;
      end
    end
  end

  // Address/data buses keep their last driven value while the port is idle.
  assign sram_csb1 = ~w_rd_issue;
  assign sram_oeb1 = r_oeb1;
  assign sram_a1   = w_rd_issue ? r_rd_ptr : r_a1_hold;
  assign sram_csb2 = ~w_sram_wr;
  assign sram_web2 = ~w_sram_wr;
  assign sram_a2   = w_sram_wr ? r_wr_ptr : r_a2_hold;
  assign sram_i2   = w_sram_wr ? enq_bits : r_i2_hold;

  assign count = CNT_W'(r_sram_cnt) + CNT_W'(r_inflight) + CNT_W'(r_ob_cnt);

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    w_push |-> (r_ob_cnt != 2'd2));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sram_fifo_ctrl                                                 |
// | Brief  : Directed self-checking bench for sram_fifo_ctrl with SRAM model.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sram_fifo_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] sram_a1;
  logic              sram_csb1;
  logic              sram_oeb1;
  logic [DATA_W-1:0] sram_o1;
  logic [ADDR_W-1:0] sram_a2;
  logic              sram_csb2;
  logic              sram_web2;
  logic [DATA_W-1:0] sram_i2;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_bits  (enq_bits),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_bits  (deq_bits),
    .count     (count),
    .sram_a1   (sram_a1),
    .sram_csb1 (sram_csb1),
    .sram_oeb1 (sram_oeb1),
    .sram_o1   (sram_o1),
    .sram_a2   (sram_a2),
    .sram_csb2 (sram_csb2),
    .sram_web2 (sram_web2),
    .sram_i2   (sram_i2)
  );

  // 1R1W macro model: read data appears the cycle after the read is issued.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int n_wr     = 0;
  int wr_wraps = 0;
  int rd_wraps = 0;

  always @(posedge clk) begin
    if (!sram_csb2 && !sram_web2) begin
      mem[sram_a2] <= sram_i2;
      n_wr         <= n_wr + 1;
      if (sram_a2 == ADDR_W'((1<<ADDR_W)-1)) wr_wraps <= wr_wraps + 1;
    end
    if (!sram_csb1) begin
      sram_o1 <= mem[sram_a1];
      if (sram_a1 == ADDR_W'((1<<ADDR_W)-1)) rd_wraps <= rd_wraps + 1;
    end
  end

  int n_total   = 0;
  int n_bad     = 0;
  int order_err = 0;
  int n_deq     = 0;
  logic [DATA_W-1:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard both handshakes, then advance one clock.
  task automatic cycle();
    logic [DATA_W-1:0] exp;
    #1;
    if (enq_valid && enq_ready) sb_q.push_back(enq_bits);
    if (deq_valid && deq_ready) begin
      n_deq++;
      if (sb_q.size() == 0) begin
        order_err++;
      end else begin
        exp = sb_q.pop_front();
        if (deq_bits !== exp) order_err++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int k = 0; k < 3000 && count != 0; k++) cycle();
    deq_ready = 1'b0;
    check("drain_empty", 32'(count), 32'd0);
  endtask

  initial begin
    int   nxt;
    int   w0;
    int   bubbles;
    int   cnt_dev;
    int   sent;
    logic acc;

    reset_n   = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_bits  = '0;

    // Reset values
    #12;
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_csb1", 32'(sram_csb1), 32'd1);
    check("rst_csb2", 32'(sram_csb2), 32'd1);
    check("rst_web2", 32'(sram_web2), 32'd1);
    check("rst_oeb1", 32'(sram_oeb1), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("oeb1_after_rel", 32'(sram_oeb1), 32'd0);

    // Bypass: one-cycle latency, no SRAM write
    w0        = n_wr;
    enq_valid = 1'b1;
    enq_bits  = 32'hA5A5_A5A5;
    #1;
    check("byp_csb2", 32'(sram_csb2), 32'd1);
    cycle();
    enq_valid = 1'b0;
    check("byp_deq_valid", 32'(deq_valid), 32'd1);
    check("byp_deq_bits", deq_bits, 32'hA5A5_A5A5);
    check("byp_count", 32'(count), 32'd1);
    check("byp_no_write", 32'(n_wr - w0), 32'd0);
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    check("byp_count_after", 32'(count), 32'd0);

    // Fill to capacity with deq blocked
    order_err = 0;
    n_deq     = 0;
    nxt       = 0;
    w0        = n_wr;
    enq_valid = 1'b1;
    for (int k = 0; k < 600 && nxt <= 600; k++) begin
      enq_bits = nxt;
      acc      = enq_ready;
      cycle();
      if (acc) nxt++;
    end
    enq_valid = 1'b0;
    check("fill_accepts", 32'(nxt), 32'd514);
    check("fill_count", 32'(count), 32'd514);
    check("fill_sram_writes", 32'(n_wr - w0), 32'd512);
    check("fill_enq_ready", 32'(enq_ready), 32'd0);
    drain();
    check("fill_n_deq", 32'(n_deq), 32'd514);
    check("fill_order", 32'(order_err), 32'd0);

    // Throughput with 4 words preloaded
    enq_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enq_bits = 32'd1000 + 32'(k);
      cycle();
    end
    check("tp_preload", 32'(count), 32'd4);
    order_err = 0;
    n_deq     = 0;
    bubbles   = 0;
    cnt_dev   = 0;
    deq_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      enq_bits = 32'd2000 + 32'(k);
      #1;
      if (!deq_valid) bubbles++;
      if (count != 10'd4) cnt_dev++;
      cycle();
    end
    check("tp_bubbles", 32'(bubbles), 32'd0);
    check("tp_count_dev", 32'(cnt_dev), 32'd0);
    check("tp_n_deq", 32'(n_deq), 32'd1000);
    check("tp_order", 32'(order_err), 32'd0);
    drain();

    // Random stream through pointer wraparound
    order_err = 0;
    n_deq     = 0;
    sent      = 0;
    for (int k = 0; k < 20000 && n_deq < 1500; k++) begin
      enq_valid = (sent < 1500) && 1'($urandom_range(1, 0));
      enq_bits  = sent;
      deq_ready = 1'($urandom_range(1, 0));
      acc       = enq_valid && enq_ready;
      cycle();
      if (acc) sent++;
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check("wrap_n_deq", 32'(n_deq), 32'd1500);
    check("wrap_order", 32'(order_err), 32'd0);
    check("wrap_wr_ptr", 32'(wr_wraps >= 2), 32'd1);
    check("wrap_rd_ptr", 32'(rd_wraps >= 2), 32'd1);

    // Full boundary
    order_err = 0;
    enq_valid = 1'b1;
    for (int k = 0; k < 600 && enq_ready; k++) begin
      enq_bits = 32'd5000 + 32'(k);
      cycle();
    end
    enq_valid = 1'b0;
    check("full_count", 32'(count), 32'd514);
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    check("full_count_pop", 32'(count), 32'd513);
    for (int k = 0; k < 2 && !enq_ready; k++) cycle();
    check("full_enq_ready", 32'(enq_ready), 32'd1);
    w0        = n_wr;
    enq_valid = 1'b1;
    enq_bits  = 32'h00C0_FFEE;
    cycle();
    enq_valid = 1'b0;
    check("full_sram_write", 32'(n_wr - w0), 32'd1);
    check("full_count_refill", 32'(count), 32'd514);
    drain();
    check("full_order", 32'(order_err), 32'd0);

    // Reset mid-stream
    enq_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      enq_bits = 32'd7000 + 32'(k);
      cycle();
    end
    enq_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("mrst_deq_valid", 32'(deq_valid), 32'd0);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_enq_ready", 32'(enq_ready), 32'd1);
    check("mrst_csb1", 32'(sram_csb1), 32'd1);
    enq_valid = 1'b1;
    #1;
    check("mrst_csb2", 32'(sram_csb2), 32'd1);
    enq_valid = 1'b0;
    sb_q.delete();
    order_err = 0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    enq_valid = 1'b1;
    enq_bits  = 32'hBEEF_0001;
    cycle();
    enq_bits  = 32'hBEEF_0002;
    cycle();
    enq_valid = 1'b0;
    check("mrst_first_valid", 32'(deq_valid), 32'd1);
    check("mrst_first_bits", deq_bits, 32'hBEEF_0001);
    drain();
    check("mrst_order", 32'(order_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
